syscon_seq: RTL and testbench

- Parametrised successor to the system clock/reset controller.
- Generates NUM_DOMAINS independent synchronous active-high reset outputs from one clock.
- Holds all resets until the clock source has been locked for HOLD_CYCLES cycles, then releases the domains one at a time, STAGGER_CYCLES apart.
- Adds lock-loss recovery, masked software reset pulses and a reset-cause register; sits between the pad/PLL interface and the bus fabric.

---
 rtl/syscon_seq.sv | 186 ++++++++++++++++++
 tb/tb_syscon_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/syscon_seq.sv
// Clock/reset sequencer: waits for a stable lock, releases reset domains one by one,
// and handles lock loss, masked software reset pulses and a sticky reset-cause register.
module syscon_seq #(
  parameter int NUM_DOMAINS     = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGGER_CYCLES  = 8,
  parameter int SW_PULSE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   locked,
  input  logic                   sw_rst_req,
  input  logic [NUM_DOMAINS-1:0] sw_rst_mask,
  output logic [NUM_DOMAINS-1:0] wb_rst,
  output logic                   ready,
  output logic [1:0]             rst_cause
);

  localparam int HW = (HOLD_CYCLES     > 1) ? $clog2(HOLD_CYCLES)     : 1;
  localparam int SW = (STAGGER_CYCLES  > 1) ? $clog2(STAGGER_CYCLES)  : 1;
  localparam int PW = (SW_PULSE_CYCLES > 1) ? $clog2(SW_PULSE_CYCLES) : 1;
  localparam int IW = (NUM_DOMAINS     > 1) ? $clog2(NUM_DOMAINS)     : 1;

  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STG_LAST   = SW'(STAGGER_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(SW_PULSE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] ONE      = NUM_DOMAINS'(1);
  localparam logic [NUM_DOMAINS-1:0] ALL_ONES = '1;

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_HOLD,
    S_RELEASE,
    S_RUN,
    S_SW_RST
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_EXT  = 2'd1,
    CAUSE_LOCK = 2'd2,
    CAUSE_SW   = 2'd3
  } cause_t;

  state_t                 state_q, state_d;
  cause_t                 cause_q, cause_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic [NUM_DOMAINS-1:0] mask_q, mask_d;
  logic                   ready_q, ready_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
  logic [SW-1:0]          stg_cnt_q, stg_cnt_d;
  logic [PW-1:0]          sw_cnt_q, sw_cnt_d;
  logic [IW-1:0]          idx_q, idx_d;

  // Lock loss must reach every domain without waiting for an edge.
  assign wb_rst    = rst_q | {NUM_DOMAINS{~locked}};
  assign ready     = ready_q;
  assign rst_cause = cause_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_WAIT_LOCK;
      cause_q    <= CAUSE_EXT;
      rst_q      <= ALL_ONES;
      mask_q     <= '0;
      ready_q    <= 1'b0;
      hold_cnt_q <= '0;
      stg_cnt_q  <= '0;
      sw_cnt_q   <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      rst_q      <= rst_d;
      mask_q     <= mask_d;
      ready_q    <= ready_d;
      hold_cnt_q <= hold_cnt_d;
      stg_cnt_q  <= stg_cnt_d;
      sw_cnt_q   <= sw_cnt_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    state_d    = state_q;
    cause_d    = cause_q;
    rst_d      = rst_q;
    mask_d     = mask_q;
    ready_d    = ready_q;
    hold_cnt_d = hold_cnt_q;
    stg_cnt_d  = stg_cnt_q;
    sw_cnt_d   = sw_cnt_q;
    idx_d      = idx_q;

    if (!locked && (state_q == S_RELEASE || state_q == S_RUN || state_q == S_SW_RST)) begin
      // Lock lost after release began: restart the whole sequence.
      state_d   = S_WAIT_LOCK;
      cause_d   = CAUSE_LOCK;
      rst_d     = ALL_ONES;
      ready_d   = 1'b0;
      stg_cnt_d = '0;
      sw_cnt_d  = '0;
      idx_d     = '0;
    end else begin
      unique case (state_q)
        S_WAIT_LOCK: begin
          if (locked) begin
            state_d    = S_HOLD;
            hold_cnt_d = '0;
          end
        end

        S_HOLD: begin
          if (!locked) begin
            state_d    = S_WAIT_LOCK;
            hold_cnt_d = '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            rst_d      = rst_q & ~ONE;
            if (NUM_DOMAINS == 1) begin
              state_d = S_RUN;
              ready_d = 1'b1;
            end else begin
              state_d   = S_RELEASE;
              idx_d     = IW'(1);
              stg_cnt_d = '0;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end

        S_RELEASE: begin
          if (stg_cnt_q == STG_LAST) begin
            stg_cnt_d = '0;
            rst_d     = rst_q & ~(ONE << idx_q);
            if (idx_q == IDX_LAST) begin
              state_d = S_RUN;
              ready_d = 1'b1;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            stg_cnt_d = stg_cnt_q + 1'b1;
          end
        end

        S_RUN: begin
          // An all-zero mask would produce an empty pulse, so it is dropped.
          if (sw_rst_req && (|sw_rst_mask)) begin
            state_d  = S_SW_RST;
            cause_d  = CAUSE_SW;
            rst_d    = rst_q | sw_rst_mask;
            mask_d   = sw_rst_mask;
            sw_cnt_d = '0;
            ready_d  = 1'b0;
          end
        end

        S_SW_RST: begin
          if (sw_cnt_q == PULSE_LAST) begin
            state_d  = S_RUN;
            rst_d    = rst_q & ~mask_q;
            ready_d  = 1'b1;
            sw_cnt_d = '0;
          end else begin
            sw_cnt_d = sw_cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = S_WAIT_LOCK;
          rst_d   = ALL_ONES;
          ready_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_syscon_seq.sv
// Directed self-checking bench for syscon_seq at default parameters.
module tb_syscon_seq;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         locked;
  logic         sw_rst_req;
  logic [N-1:0] sw_rst_mask;
  logic [N-1:0] wb_rst;
  logic         ready;
  logic [1:0]   rst_cause;

  int errors = 0;
  int checks = 0;

  syscon_seq #(
    .NUM_DOMAINS(4),
    .HOLD_CYCLES(16),
    .STAGGER_CYCLES(8),
    .SW_PULSE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .locked     (locked),
    .sw_rst_req (sw_rst_req),
    .sw_rst_mask(sw_rst_mask),
    .wb_rst     (wb_rst),
    .ready      (ready),
    .rst_cause  (rst_cause)
  );

  always #5 clk = ~clk;

  // One active edge; inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected wb_rst after the k-th consecutive locked edge from WAIT_LOCK:
  // domain 0 at edge 17, then one more domain every 8 edges.
  function automatic logic [3:0] exp_rel(input int k);
    logic [3:0] v;
    int n;
    v = 4'hF;
    if (k < 17) return v;
    n = (k - 17) / 8 + 1;
    if (n > 4) n = 4;
    v = v << n;
    return v;
  endfunction

  task automatic run_release(input string name, input int upto, input logic [1:0] cause);
    for (int k = 1; k <= upto; k++) begin
      tick();
      checks++;
      if (wb_rst !== exp_rel(k)) begin
        errors++;
        $display("FAIL %s edge=%0d wb_rst=%b expected %b", name, k, wb_rst, exp_rel(k));
      end
      checks++;
      if (ready !== (k >= 41)) begin
        errors++;
        $display("FAIL %s edge=%0d ready=%b expected %b", name, k, ready, (k >= 41));
      end
      checks++;
      if (rst_cause !== cause) begin
        errors++;
        $display("FAIL %s edge=%0d rst_cause=%0d expected %0d", name, k, rst_cause, cause);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; locked = 1'b0; sw_rst_req = 1'b0; sw_rst_mask = '0;
    tick();
    locked = 1'b1;
    tick();
    checks++;
    if (wb_rst !== 4'b1111) begin
      errors++; $display("FAIL reset_wb_rst actual=%b expected 1111", wb_rst);
    end
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready actual=%b expected 0", ready);
    end
    checks++;
    if (rst_cause !== 2'd1) begin
      errors++; $display("FAIL reset_cause actual=%0d expected 1", rst_cause);
    end
  endtask

  task automatic test_release();
    rst = 1'b0; locked = 1'b1;
    run_release("release", 42, 2'd1);
  endtask

  task automatic test_lock_glitch_hold();
    rst = 1'b1;
    tick();
    rst = 1'b0; locked = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (wb_rst !== 4'b1111) begin
        errors++; $display("FAIL glitch_hold edge=%0d wb_rst=%b expected 1111", i, wb_rst);
      end
    end
    locked = 1'b0;
    tick();
    checks++;
    if (wb_rst !== 4'b1111) begin
      errors++; $display("FAIL glitch_low wb_rst=%b expected 1111", wb_rst);
    end
    checks++;
    if (rst_cause !== 2'd1) begin
      errors++; $display("FAIL glitch_cause actual=%0d expected 1", rst_cause);
    end
    locked = 1'b1;
    run_release("glitch_release", 42, 2'd1);
  endtask

  task automatic test_lock_loss_run();
    locked = 1'b0;
    #1;
    checks++;
    if (wb_rst !== 4'b1111) begin
      errors++; $display("FAIL lockloss_same_cycle wb_rst=%b expected 1111", wb_rst);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL lockloss_ready_before_edge actual=%b expected 1", ready);
    end
    tick();
    locked = 1'b1;
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL lockloss_ready actual=%b expected 0", ready);
    end
    checks++;
    if (rst_cause !== 2'd2) begin
      errors++; $display("FAIL lockloss_cause actual=%0d expected 2", rst_cause);
    end
    checks++;
    if (wb_rst !== 4'b1111) begin
      errors++; $display("FAIL lockloss_wb_rst actual=%b expected 1111", wb_rst);
    end
    run_release("lockloss_rerun", 42, 2'd2);
  endtask

  task automatic test_sw_reset();
    sw_rst_req = 1'b1; sw_rst_mask = 4'b0110;
    tick();
    sw_rst_req = 1'b0; sw_rst_mask = '0;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) tick();
      checks++;
      if (wb_rst !== 4'b0110) begin
        errors++; $display("FAIL sw_pulse cycle=%0d wb_rst=%b expected 0110", i, wb_rst);
      end
      checks++;
      if (ready !== 1'b0) begin
        errors++; $display("FAIL sw_pulse_ready cycle=%0d actual=%b expected 0", i, ready);
      end
    end
    checks++;
    if (rst_cause !== 2'd3) begin
      errors++; $display("FAIL sw_cause actual=%0d expected 3", rst_cause);
    end
    tick();
    checks++;
    if (wb_rst !== 4'b0000 || ready !== 1'b1) begin
      errors++; $display("FAIL sw_end wb_rst=%b ready=%b expected 0000/1", wb_rst, ready);
    end
    // Zero mask must be ignored.
    sw_rst_req = 1'b1; sw_rst_mask = 4'b0000;
    tick();
    sw_rst_req = 1'b0;
    tick();
    checks++;
    if (wb_rst !== 4'b0000 || ready !== 1'b1 || rst_cause !== 2'd3) begin
      errors++;
      $display("FAIL sw_zero_mask wb_rst=%b ready=%b cause=%0d expected 0000/1/3", wb_rst, ready, rst_cause);
    end
    // A request during the pulse must not extend or widen it.
    sw_rst_req = 1'b1; sw_rst_mask = 4'b0001;
    tick();
    sw_rst_mask = 4'b1000;
    tick();
    sw_rst_req = 1'b0; sw_rst_mask = '0;
    checks++;
    if (wb_rst !== 4'b0001) begin
      errors++; $display("FAIL sw_ignore_mid wb_rst=%b expected 0001", wb_rst);
    end
    tick();
    tick();
    checks++;
    if (wb_rst !== 4'b0001) begin
      errors++; $display("FAIL sw_ignore_last wb_rst=%b expected 0001", wb_rst);
    end
    tick();
    checks++;
    if (wb_rst !== 4'b0000 || ready !== 1'b1) begin
      errors++; $display("FAIL sw_ignore_end wb_rst=%b ready=%b expected 0000/1", wb_rst, ready);
    end
  endtask

  task automatic test_sw_lockloss();
    sw_rst_req = 1'b1; sw_rst_mask = 4'b0110;
    tick();
    sw_rst_mask = 4'b1001; locked = 1'b0;
    #1;
    checks++;
    if (wb_rst !== 4'b1111) begin
      errors++; $display("FAIL swloss_same_cycle wb_rst=%b expected 1111", wb_rst);
    end
    tick();
    sw_rst_req = 1'b0; sw_rst_mask = '0; locked = 1'b1;
    checks++;
    if (wb_rst !== 4'b1111 || ready !== 1'b0) begin
      errors++; $display("FAIL swloss_state wb_rst=%b ready=%b expected 1111/0", wb_rst, ready);
    end
    checks++;
    if (rst_cause !== 2'd2) begin
      errors++; $display("FAIL swloss_cause actual=%0d expected 2", rst_cause);
    end
    run_release("swloss_rerun", 42, 2'd2);
  endtask

  task automatic test_rst_mid_release();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    run_release("mid_release", 26, 2'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (wb_rst !== 4'b1111 || ready !== 1'b0) begin
      errors++; $display("FAIL midrst_state wb_rst=%b ready=%b expected 1111/0", wb_rst, ready);
    end
    checks++;
    if (rst_cause !== 2'd1) begin
      errors++; $display("FAIL midrst_cause actual=%0d expected 1", rst_cause);
    end
    run_release("midrst_rerun", 42, 2'd1);
  endtask

  initial begin
    rst = 1'b1; locked = 1'b0; sw_rst_req = 1'b0; sw_rst_mask = '0;
    @(negedge clk);
    test_reset();
    test_release();
    test_lock_glitch_hold();
    test_lock_loss_run();
    test_sw_reset();
    test_sw_lockloss();
    test_rst_mid_release();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
